// File: rtl/branch_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_sched_if
//  Purpose  : Bundle of dispatch, wakeup, issue, resolution and redirect
//             signals between the core and the branch scheduler.
//  Modports : master - core side (drives dispatch/wake/resolve/flush)
//             slave  - scheduler side (drives ready/issue/redirect/busy)
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_sched_if #(
    parameter int TAGW = 6
);
    logic [1:0]            disp_valid;
    logic [1:0][31:0]      disp_pc;
    logic [1:0][2:0]       disp_type;
    logic [1:0][31:0]      disp_off;
    logic [1:0][TAGW-1:0]  disp_rs_tag;
    logic [1:0][TAGW-1:0]  disp_rt_tag;
    logic [1:0]            disp_rs_rdy;
    logic [1:0]            disp_rt_rdy;
    logic [1:0][31:0]      disp_rs_val;
    logic [1:0][31:0]      disp_rt_val;
    logic                  disp_ready;
    logic                  wake_valid;
    logic [TAGW-1:0]       wake_tag;
    logic [31:0]           wake_data;
    logic                  iss_valid;
    logic                  iss_ready;
    logic [31:0]           iss_pc;
    logic [31:0]           iss_off;
    logic [31:0]           iss_rs;
    logic [31:0]           iss_rt;
    logic [2:0]            iss_type;
    logic                  res_valid;
    logic                  res_mispredict;
    logic [31:0]           res_target;
    logic                  ext_flush;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  busy;

    modport master (
        output disp_valid, disp_pc, disp_type, disp_off, disp_rs_tag, disp_rt_tag,
               disp_rs_rdy, disp_rt_rdy, disp_rs_val, disp_rt_val,
               wake_valid, wake_tag, wake_data, iss_ready,
               res_valid, res_mispredict, res_target, ext_flush,
        input  disp_ready, iss_valid, iss_pc, iss_off, iss_rs, iss_rt, iss_type,
               redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  disp_valid, disp_pc, disp_type, disp_off, disp_rs_tag, disp_rt_tag,
               disp_rs_rdy, disp_rt_rdy, disp_rs_val, disp_rt_val,
               wake_valid, wake_tag, wake_data, iss_ready,
               res_valid, res_mispredict, res_target, ext_flush,
        output disp_ready, iss_valid, iss_pc, iss_off, iss_rs, iss_rt, iss_type,
               redirect_valid, redirect_pc, busy
    );
endinterface
`default_nettype wire

// File: rtl/branch_sched.sv
`default_nettype none
// ============================================================================
//  Module   : branch_sched
//  Purpose  : In-order scheduler for the single branch resolution unit.
//             Queues up to two branches per cycle, captures operands from
//             the wakeup bus, issues the oldest ready branch with at most
//             one outstanding, and turns a mispredict into flush+redirect.
//  Ports    : clk, rst (synchronous, active-high)
//             bus - branch_sched_if.slave (dispatch, wakeup, issue,
//                   resolution, external flush, redirect, busy)
//  Revision : 1.0 - initial release
// ============================================================================
module branch_sched #(
    parameter int DEPTH = 4,
    parameter int TAGW  = 6
) (
    input  wire logic     clk,
    input  wire logic     rst,
    branch_sched_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef struct packed {
        logic [31:0]     pc;
        logic [2:0]      typ;
        logic [31:0]     off;
        logic [TAGW-1:0] rs_tag;
        logic [TAGW-1:0] rt_tag;
        logic            rs_rdy;
        logic            rt_rdy;
        logic [31:0]     rs_val;
        logic [31:0]     rt_val;
    } entry_t;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          redirect_valid_q, redirect_valid_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic [DEPTH-1:0] valid_q;
    entry_t        ent_q [DEPTH];

    logic          w_res_ok, w_mispred, w_clear, w_disp_ready, w_accept;
    logic          w_push0, w_push1, w_iss_valid, w_pop;
    logic [PW-1:0] w_wr1_idx;
    entry_t        w_head;

    // Incoming slots with same-cycle wakeup already folded in.
    for (genvar s = 0; s < 2; s++) begin : g_slot
        entry_t w_new;
        always_comb begin
            w_new        = '0;
            w_new.pc     = bus.disp_pc[s];
            w_new.typ    = bus.disp_type[s];
            w_new.off    = bus.disp_off[s];
            w_new.rs_tag = bus.disp_rs_tag[s];
            w_new.rt_tag = bus.disp_rt_tag[s];
            w_new.rs_rdy = bus.disp_rs_rdy[s] |
                           (bus.wake_valid && (bus.wake_tag == bus.disp_rs_tag[s]));
            w_new.rt_rdy = bus.disp_rt_rdy[s] |
                           (bus.wake_valid && (bus.wake_tag == bus.disp_rt_tag[s]));
            w_new.rs_val = bus.disp_rs_rdy[s] ? bus.disp_rs_val[s] : bus.wake_data;
            w_new.rt_val = bus.disp_rt_rdy[s] ? bus.disp_rt_val[s] : bus.wake_data;
        end
    end

    assign w_head       = ent_q[head_q];
    // A result is only meaningful while a branch is outstanding, and an
    // external flush in the same cycle wins over it.
    assign w_res_ok     = (state_q == ST_WAIT) && bus.res_valid && !bus.ext_flush;
    assign w_mispred    = w_res_ok && bus.res_mispredict;
    assign w_clear      = bus.ext_flush || w_mispred;
    // Two free entries guaranteed, so a dual dispatch never partially fits.
    assign w_disp_ready = (state_q != ST_FLUSH) && (count_q <= CW'(DEPTH - 2));
    assign w_accept     = w_disp_ready && !w_clear;
    assign w_push0      = w_accept && bus.disp_valid[0];
    assign w_push1      = w_accept && bus.disp_valid[1];
    assign w_wr1_idx    = tail_q + PW'(w_push0);
    assign w_iss_valid  = (state_q == ST_RUN) && (count_q != '0) &&
                          w_head.rs_rdy && w_head.rt_rdy;
    assign w_pop        = w_iss_valid && bus.iss_ready;

    always_comb begin
        state_d          = state_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (bus.ext_flush) begin
            state_d = ST_RUN;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (w_mispred) begin
            state_d          = ST_FLUSH;
            head_d           = '0;
            tail_d           = '0;
            count_d          = '0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = bus.res_target;
        end else begin
            head_d  = head_q + PW'(w_pop);
            tail_d  = tail_q + PW'(w_push0) + PW'(w_push1);
            count_d = count_q + CW'(w_push0) + CW'(w_push1) - CW'(w_pop);
            case (state_q)
                ST_RUN:   if (w_pop)    state_d = ST_WAIT;
                ST_WAIT:  if (w_res_ok) state_d = ST_RUN;
                ST_FLUSH: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    // Entry storage: writes land only on free slots, so a write never
    // collides with a pop (head) or a wakeup of a live entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                valid_q[i] <= 1'b0;
                ent_q[i]   <= '0;
            end else if (w_clear) begin
                valid_q[i] <= 1'b0;
            end else if (w_push0 && (tail_q == PW'(i))) begin
                valid_q[i] <= 1'b1;
                ent_q[i]   <= g_slot[0].w_new;
            end else if (w_push1 && (w_wr1_idx == PW'(i))) begin
                valid_q[i] <= 1'b1;
                ent_q[i]   <= g_slot[1].w_new;
            end else begin
                if (w_pop && (head_q == PW'(i))) begin
                    valid_q[i] <= 1'b0;
                end
                if (valid_q[i] && bus.wake_valid) begin
                    if (!ent_q[i].rs_rdy && (ent_q[i].rs_tag == bus.wake_tag)) begin
                        ent_q[i].rs_rdy <= 1'b1;
                        ent_q[i].rs_val <= bus.wake_data;
                    end
                    if (!ent_q[i].rt_rdy && (ent_q[i].rt_tag == bus.wake_tag)) begin
                        ent_q[i].rt_rdy <= 1'b1;
                        ent_q[i].rt_val <= bus.wake_data;
                    end
                end
            end
        end
    end

    assign bus.disp_ready     = w_disp_ready;
    assign bus.iss_valid      = w_iss_valid;
    assign bus.iss_pc         = w_head.pc;
    assign bus.iss_type       = w_head.typ;
    assign bus.iss_off        = w_head.off;
    assign bus.iss_rs         = w_head.rs_val;
    assign bus.iss_rt         = w_head.rt_val;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = (count_q != '0) || (state_q == ST_WAIT);
endmodule
`default_nettype wire

// File: tb/tb_branch_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_sched
//  Purpose  : Directed scoreboard bench for branch_sched (DEPTH=4, TAGW=6).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_sched;
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [31:0] off;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    exp_t        exp_q[$];
    logic [31:0] redir_q[$];

    branch_sched_if #(.TAGW(6)) bif ();
    branch_sched #(.DEPTH(4), .TAGW(6)) dut (.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted issue and every redirect pulse.
    always @(negedge clk) begin
        if (bif.iss_valid && bif.iss_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL iss_unexpected: got pc=%h with nothing expected", bif.iss_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({bif.iss_pc, bif.iss_type, bif.iss_off, bif.iss_rs, bif.iss_rt} !== e) begin
                    errors++;
                    $display("FAIL iss_payload: got pc=%h type=%0d off=%h rs=%h rt=%h expected pc=%h type=%0d off=%h rs=%h rt=%h",
                             bif.iss_pc, bif.iss_type, bif.iss_off, bif.iss_rs, bif.iss_rt,
                             e.pc, e.typ, e.off, e.rs, e.rt);
                end
            end
        end
        if (bif.redirect_valid) begin
            vectors++;
            if (redir_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got pc=%h with nothing expected", bif.redirect_pc);
            end else begin
                logic [31:0] r;
                r = redir_q.pop_front();
                if (bif.redirect_pc !== r) begin
                    errors++;
                    $display("FAIL redirect_pc: got %h expected %h", bif.redirect_pc, r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp_slot(input int s, input logic [31:0] pc, input logic [2:0] typ,
                             input logic [31:0] off,
                             input logic [5:0] rs_tag, input logic rs_rdy, input logic [31:0] rs_val,
                             input logic [5:0] rt_tag, input logic rt_rdy, input logic [31:0] rt_val);
        bif.disp_valid[s]  = 1'b1;
        bif.disp_pc[s]     = pc;
        bif.disp_type[s]   = typ;
        bif.disp_off[s]    = off;
        bif.disp_rs_tag[s] = rs_tag;
        bif.disp_rs_rdy[s] = rs_rdy;
        bif.disp_rs_val[s] = rs_val;
        bif.disp_rt_tag[s] = rt_tag;
        bif.disp_rt_rdy[s] = rt_rdy;
        bif.disp_rt_val[s] = rt_val;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [2:0] typ, input logic [31:0] off,
                            input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        e.pc = pc; e.typ = typ; e.off = off; e.rs = rs; e.rt = rt;
        exp_q.push_back(e);
    endtask

    task automatic resolve(input logic mis, input logic [31:0] target);
        bif.res_valid      = 1'b1;
        bif.res_mispredict = mis;
        bif.res_target     = target;
        tick();
        bif.res_valid      = 1'b0;
        bif.res_mispredict = 1'b0;
    endtask

    // Wait (bounded) for the head to issue, let it go, then resolve it.
    task automatic drain_one();
        int n = 0;
        while (!bif.iss_valid && n < 20) begin
            tick();
            n++;
        end
        chk("drain_issue", {31'd0, bif.iss_valid}, 32'd1);
        tick();
        resolve(1'b0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.disp_valid = '0;  bif.disp_pc = '0;     bif.disp_type = '0;  bif.disp_off = '0;
        bif.disp_rs_tag = '0; bif.disp_rt_tag = '0; bif.disp_rs_rdy = '0; bif.disp_rt_rdy = '0;
        bif.disp_rs_val = '0; bif.disp_rt_val = '0;
        bif.wake_valid = 1'b0; bif.wake_tag = '0; bif.wake_data = '0;
        bif.iss_ready = 1'b1;
        bif.res_valid = 1'b0; bif.res_mispredict = 1'b0; bif.res_target = '0;
        bif.ext_flush = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_iss_valid",  {31'd0, bif.iss_valid}, 32'd0);
        chk("rst_redir_v",    {31'd0, bif.redirect_valid}, 32'd0);
        chk("rst_redir_pc",   bif.redirect_pc, 32'd0);
        chk("rst_busy",       {31'd0, bif.busy}, 32'd0);
        chk("rst_disp_ready", {31'd0, bif.disp_ready}, 32'd1);

        // Single beq, operands ready
        disp_slot(0, 32'h0040_0010, 3'd0, 32'h0000_0020, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd5);
        push_exp(32'h0040_0010, 3'd0, 32'h0000_0020, 32'd5, 32'd5);
        tick();
        bif.disp_valid = '0;
        chk("t1_iss_valid", {31'd0, bif.iss_valid}, 32'd1);
        chk("t1_iss_pc",    bif.iss_pc, 32'h0040_0010);
        tick();
        chk("t1_wait_iss",  {31'd0, bif.iss_valid}, 32'd0);
        chk("t1_wait_busy", {31'd0, bif.busy}, 32'd1);
        resolve(1'b0, 32'd0);
        chk("t1_busy_done", {31'd0, bif.busy}, 32'd0);
        chk("t1_no_redir",  {31'd0, bif.redirect_valid}, 32'd0);

        // Dual dispatch, in-order issue, one outstanding
        bif.iss_ready = 1'b0;
        disp_slot(0, 32'h0000_0100, 3'd1, 32'h0000_0008, 6'd3, 1'b1, 32'h11, 6'd4, 1'b1, 32'h22);
        disp_slot(1, 32'h0000_0104, 3'd5, 32'hFFFF_FFF0, 6'd5, 1'b1, 32'h33, 6'd6, 1'b1, 32'h44);
        push_exp(32'h0000_0100, 3'd1, 32'h0000_0008, 32'h11, 32'h22);
        push_exp(32'h0000_0104, 3'd5, 32'hFFFF_FFF0, 32'h33, 32'h44);
        tick();
        bif.disp_valid = '0;
        chk("t2_disp_ready", {31'd0, bif.disp_ready}, 32'd1);
        chk("t2_iss_pc",     bif.iss_pc, 32'h0000_0100);
        bif.iss_ready = 1'b1;
        tick();
        tick();
        chk("t2_hold_second", {31'd0, bif.iss_valid}, 32'd0);
        resolve(1'b0, 32'd0);
        chk("t2_second_pc", bif.iss_pc, 32'h0000_0104);
        chk("t2_second_v",  {31'd0, bif.iss_valid}, 32'd1);
        tick();
        resolve(1'b0, 32'd0);

        // Wakeup after dispatch
        disp_slot(0, 32'h0000_0200, 3'd3, 32'h0000_0004, 6'd12, 1'b0, 32'd0, 6'd1, 1'b1, 32'd3);
        push_exp(32'h0000_0200, 3'd3, 32'h0000_0004, 32'hFFFF_FFFF, 32'd3);
        tick();
        bif.disp_valid = '0;
        chk("t3_not_ready", {31'd0, bif.iss_valid}, 32'd0);
        bif.wake_valid = 1'b1; bif.wake_tag = 6'd12; bif.wake_data = 32'hFFFF_FFFF;
        tick();
        bif.wake_valid = 1'b0;
        chk("t3_woken_v",  {31'd0, bif.iss_valid}, 32'd1);
        chk("t3_woken_rs", bif.iss_rs, 32'hFFFF_FFFF);
        tick();
        resolve(1'b0, 32'd0);

        // Wakeup in the same cycle as dispatch
        disp_slot(0, 32'h0000_0204, 3'd4, 32'h0000_000C, 6'd2, 1'b1, 32'd7, 6'd20, 1'b0, 32'h0000_0BAD);
        push_exp(32'h0000_0204, 3'd4, 32'h0000_000C, 32'd7, 32'h1234_5678);
        bif.wake_valid = 1'b1; bif.wake_tag = 6'd20; bif.wake_data = 32'h1234_5678;
        tick();
        bif.disp_valid = '0; bif.wake_valid = 1'b0;
        chk("t3_same_v",  {31'd0, bif.iss_valid}, 32'd1);
        chk("t3_same_rt", bif.iss_rt, 32'h1234_5678);
        tick();
        resolve(1'b0, 32'd0);

        // Both operands from one broadcast; a non-matching tag must not wake
        disp_slot(0, 32'h0000_0208, 3'd6, 32'h0000_0010, 6'd33, 1'b0, 32'd0, 6'd33, 1'b0, 32'd0);
        push_exp(32'h0000_0208, 3'd6, 32'h0000_0010, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        tick();
        bif.disp_valid = '0;
        bif.wake_valid = 1'b1; bif.wake_tag = 6'd34; bif.wake_data = 32'h0BAD_0BAD;
        tick();
        chk("t3_wrong_tag", {31'd0, bif.iss_valid}, 32'd0);
        bif.wake_tag = 6'd33; bif.wake_data = 32'hA5A5_A5A5;
        tick();
        bif.wake_valid = 1'b0;
        chk("t3_both_v", {31'd0, bif.iss_valid}, 32'd1);
        tick();
        resolve(1'b0, 32'd0);

        // Fill to 3, slot-1-only dispatch, type 7 passthrough, drop when full
        bif.iss_ready = 1'b0;
        disp_slot(0, 32'h0000_0300, 3'd0, 32'h0000_0040, 6'd1, 1'b1, 32'd1, 6'd2, 1'b1, 32'd2);
        disp_slot(1, 32'h0000_0304, 3'd7, 32'h0000_0044, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd4);
        push_exp(32'h0000_0300, 3'd0, 32'h0000_0040, 32'd1, 32'd2);
        push_exp(32'h0000_0304, 3'd7, 32'h0000_0044, 32'd3, 32'd4);
        tick();
        bif.disp_valid = '0;
        chk("t4_ready_at2", {31'd0, bif.disp_ready}, 32'd1);
        disp_slot(1, 32'h0000_0308, 3'd1, 32'h0000_0048, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd6);
        push_exp(32'h0000_0308, 3'd1, 32'h0000_0048, 32'd5, 32'd6);
        tick();
        bif.disp_valid = '0;
        chk("t4_full_ready", {31'd0, bif.disp_ready}, 32'd0);
        disp_slot(0, 32'h0000_030C, 3'd2, 32'h0000_004C, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9);
        tick();
        bif.disp_valid = '0;
        chk("t4_still_full", {31'd0, bif.disp_ready}, 32'd0);
        bif.iss_ready = 1'b1;
        tick();
        chk("t4_ready_after_pop", {31'd0, bif.disp_ready}, 32'd1);
        resolve(1'b0, 32'd0);
        drain_one();
        drain_one();
        chk("t4_drained_busy", {31'd0, bif.busy}, 32'd0);

        // Mispredict with 3 queued behind the outstanding branch
        bif.iss_ready = 1'b0;
        disp_slot(0, 32'h0000_0400, 3'd0, 32'h0000_0080, 6'd1, 1'b1, 32'h40, 6'd2, 1'b1, 32'h41);
        disp_slot(1, 32'h0000_0404, 3'd1, 32'h0000_0084, 6'd1, 1'b1, 32'h42, 6'd2, 1'b1, 32'h43);
        push_exp(32'h0000_0400, 3'd0, 32'h0000_0080, 32'h40, 32'h41);
        tick();
        bif.disp_valid = '0;
        disp_slot(0, 32'h0000_0408, 3'd3, 32'h0000_0088, 6'd1, 1'b1, 32'h44, 6'd2, 1'b1, 32'h45);
        bif.iss_ready = 1'b1;
        tick();
        disp_slot(0, 32'h0000_040C, 3'd4, 32'h0000_008C, 6'd1, 1'b1, 32'h46, 6'd2, 1'b1, 32'h47);
        tick();
        bif.disp_valid = '0;
        chk("t5_full_ready", {31'd0, bif.disp_ready}, 32'd0);
        redir_q.push_back(32'h0040_0200);
        resolve(1'b1, 32'h0040_0200);
        exp_q.delete();
        chk("t5_redir_v",   {31'd0, bif.redirect_valid}, 32'd1);
        chk("t5_redir_pc",  bif.redirect_pc, 32'h0040_0200);
        chk("t5_flush_rdy", {31'd0, bif.disp_ready}, 32'd0);
        chk("t5_flush_busy", {31'd0, bif.busy}, 32'd0);
        disp_slot(0, 32'h0000_0500, 3'd0, 32'h0, 6'd1, 1'b1, 32'h1, 6'd2, 1'b1, 32'h2);
        tick();
        bif.disp_valid = '0;
        chk("t5_redir_pulse", {31'd0, bif.redirect_valid}, 32'd0);
        chk("t5_resume_rdy",  {31'd0, bif.disp_ready}, 32'd1);
        chk("t5_dropped",     {31'd0, bif.busy}, 32'd0);

        // ext_flush together with a mispredict result in WAIT
        disp_slot(0, 32'h0000_0600, 3'd2, 32'h0000_00A0, 6'd1, 1'b1, 32'h60, 6'd2, 1'b1, 32'h61);
        push_exp(32'h0000_0600, 3'd2, 32'h0000_00A0, 32'h60, 32'h61);
        tick();
        disp_slot(0, 32'h0000_0604, 3'd5, 32'h0000_00A4, 6'd1, 1'b1, 32'h62, 6'd2, 1'b1, 32'h63);
        tick();
        bif.disp_valid = '0;
        bif.ext_flush = 1'b1;
        resolve(1'b1, 32'hDEAD_BEEC);
        bif.ext_flush = 1'b0;
        exp_q.delete();
        chk("t6_no_redir",  {31'd0, bif.redirect_valid}, 32'd0);
        chk("t6_busy",      {31'd0, bif.busy}, 32'd0);
        chk("t6_disp_rdy",  {31'd0, bif.disp_ready}, 32'd1);
        tick();
        chk("t6_no_redir2", {31'd0, bif.redirect_valid}, 32'd0);

        // rst while a branch is outstanding
        disp_slot(0, 32'h0000_0700, 3'd0, 32'h0000_00B0, 6'd1, 1'b1, 32'h70, 6'd2, 1'b1, 32'h71);
        push_exp(32'h0000_0700, 3'd0, 32'h0000_00B0, 32'h70, 32'h71);
        tick();
        disp_slot(0, 32'h0000_0704, 3'd1, 32'h0000_00B4, 6'd1, 1'b1, 32'h72, 6'd2, 1'b1, 32'h73);
        tick();
        bif.disp_valid = '0;
        chk("t7_wait_busy", {31'd0, bif.busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("t7_iss_valid",  {31'd0, bif.iss_valid}, 32'd0);
        chk("t7_redir_v",    {31'd0, bif.redirect_valid}, 32'd0);
        chk("t7_redir_pc",   bif.redirect_pc, 32'd0);
        chk("t7_busy",       {31'd0, bif.busy}, 32'd0);
        chk("t7_disp_ready", {31'd0, bif.disp_ready}, 32'd1);

        repeat (3) tick();
        chk("end_exp_empty",   exp_q.size(), 32'd0);
        chk("end_redir_empty", redir_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
